// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared types and constants for the debug snapshot controller
package dbg_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DUMP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_BP      = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_FORCE   = 2'd3
    } cause_t;

endpackage

// File: rtl/bp_match.sv
// rtl/bp_match.sv - parallel PC breakpoint comparators with lowest-index priority
module bp_match #(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 4
) (
    input  logic                   pc_valid,
    input  logic [XLEN-1:0]        pc,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*XLEN-1:0] bp_addr,
    output logic                   hit,
    output logic [2:0]             hit_id
);

    // Scan from the top down so the lowest matching slot is the last write.
    always_comb begin
        hit    = 1'b0;
        hit_id = 3'd0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (pc_valid && bp_en[k] && (pc == bp_addr[k*XLEN +: XLEN])) begin
                hit    = 1'b1;
                hit_id = 3'(k);
            end
        end
    end

endmodule

// File: rtl/dbg_snapshot_ctrl.sv
// rtl/dbg_snapshot_ctrl.sv - halt-on-trigger register snapshot streamer
// Optional timeout trigger enabled by macro DBG_SNAPSHOT_TIMEOUT_EN.
module dbg_snapshot_ctrl
    import dbg_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_BP  = 4,
    parameter int NREGS   = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm_i,
    input  logic                   force_i,
    input  logic [NUM_BP-1:0]      bp_en_i,
    input  logic [NUM_BP*XLEN-1:0] bp_addr_i,
    input  logic [XLEN-1:0]        pc_i,
    input  logic                   pc_valid_i,
    output logic                   halt_o,
    output logic [REG_IDX_W-1:0]   reg_sel_o,
    input  logic [XLEN-1:0]        reg_data_i,
    output logic                   snap_valid_o,
    input  logic                   snap_ready_i,
    output logic [REG_IDX_W-1:0]   snap_idx_o,
    output logic [XLEN-1:0]        snap_data_o,
    output logic [1:0]             cause_o,
    output logic [2:0]             hit_id_o,
    output logic [CNT_W-1:0]       cycle_cnt_o,
    output logic                   done_o
);

    localparam logic [CNT_W-1:0]       CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
    localparam logic [REG_IDX_W:0]     LD_END   = (REG_IDX_W + 1)'(NREGS);
    localparam logic [REG_IDX_W:0]     LD_ONE   = (REG_IDX_W + 1)'(1);
    localparam logic [REG_IDX_W-1:0]   LAST_IDX = REG_IDX_W'(NREGS - 1);

    state_t               state;
    logic                 bp_hit;
    logic [2:0]           bp_id;
    logic                 tmo_hit;
    logic [REG_IDX_W:0]   ld_idx;
    logic                 more;
    logic                 xfer;
    logic                 load;

    bp_match #(
        .XLEN   (XLEN),
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .pc_valid (pc_valid_i),
        .pc       (pc_i),
        .bp_en    (bp_en_i),
        .bp_addr  (bp_addr_i),
        .hit      (bp_hit),
        .hit_id   (bp_id)
    );

`ifdef DBG_SNAPSHOT_TIMEOUT_EN
    assign tmo_hit = (cycle_cnt_o == CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // ld_idx runs one word ahead of snap_idx_o so a new word loads in the
    // same cycle the current one is accepted.
    assign reg_sel_o = ld_idx[REG_IDX_W-1:0];
    assign more      = (ld_idx < LD_END);
    assign xfer      = snap_valid_o && snap_ready_i;
    assign load      = (!snap_valid_o || snap_ready_i) && more;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            halt_o       <= 1'b0;
            snap_valid_o <= 1'b0;
            done_o       <= 1'b0;
            cause_o      <= CAUSE_NONE;
            hit_id_o     <= 3'd0;
            cycle_cnt_o  <= '0;
            snap_idx_o   <= '0;
            snap_data_o  <= '0;
            ld_idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm_i) begin
                        state       <= RUN;
                        cycle_cnt_o <= '0;
                    end
                end
                RUN: begin
                    if (cycle_cnt_o != CNT_MAX) cycle_cnt_o <= cycle_cnt_o + CNT_ONE;
                    if (bp_hit || tmo_hit || force_i) begin
                        state      <= DUMP;
                        halt_o     <= 1'b1;
                        snap_idx_o <= '0;
                        ld_idx     <= '0;
                        if (bp_hit) begin
                            cause_o  <= CAUSE_BP;
                            hit_id_o <= bp_id;
                        end else if (tmo_hit) begin
                            cause_o  <= CAUSE_TIMEOUT;
                            hit_id_o <= 3'd0;
                        end else begin
                            cause_o  <= CAUSE_FORCE;
                            hit_id_o <= 3'd0;
                        end
                    end
                end
                DUMP: begin
                    if (load) begin
                        snap_data_o  <= (ld_idx == '0) ? '0 : reg_data_i;
                        snap_valid_o <= 1'b1;
                        snap_idx_o   <= ld_idx[REG_IDX_W-1:0];
                        ld_idx       <= ld_idx + LD_ONE;
                    end else if (xfer) begin
                        snap_valid_o <= 1'b0;
                    end
                    if (xfer && (snap_idx_o == LAST_IDX)) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (arm_i) begin
                        state       <= RUN;
                        halt_o      <= 1'b0;
                        done_o      <= 1'b0;
                        cause_o     <= CAUSE_NONE;
                        hit_id_o    <= 3'd0;
                        cycle_cnt_o <= '0;
                        ld_idx      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
